// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// Decodes the immediate of a RISC-V instruction word, sign/zero-extends it
// to XLEN, precomputes pc + imm, and passes the result through a 2-entry
// skid buffer with a valid/ready handshake on both sides.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     upstream beat valid
//   in_ready     block can accept a beat (registered)
//   in_instr     32-bit instruction word
//   in_pc        instruction address, XLEN bits
//   flush        discard every buffered beat and any beat offered this cycle
//   out_valid    output beat valid
//   out_ready    downstream accepts the output beat
//   out_imm      extended immediate
//   out_fmt      0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
//   out_pc       pc of the output beat
//   out_target   out_pc + out_imm, wrapping modulo 2^XLEN
//   out_illegal  unrecognised encoding
module imm_decode_stage #(
  parameter int XLEN    = 32,
  parameter bit ZIMM_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            accept;
  logic            drain;

  logic [6:0]      opcode;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_target;

  // Second (skid) entry; the head entry is the out_* register set itself.
  logic [XLEN-1:0] skid_imm;
  logic [2:0]      skid_fmt;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_target;
  logic            skid_illegal;

  assign opcode = in_instr[6:0];
  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Decode on the input side so both entries hold finished results.
  // Size casts of $signed operands sign-extend to XLEN.
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(in_instr[31:20]));
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                 in_instr[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0}));
      end
      7'b1110011: begin
        // Only the CSR-immediate forms carry an immediate; the rest of SYSTEM is legal without one.
        if (ZIMM_EN && in_instr[14]) begin
          dec_fmt = FMT_Z;
          dec_imm = XLEN'(in_instr[19:15]);
        end
      end
      7'b0110011, 7'b0001111: begin
        dec_fmt = FMT_NONE;
      end
      7'b0111011: begin
        // OP-32 only exists on RV64.
        dec_illegal = (XLEN != 64);
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_target = in_pc + dec_imm;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE: begin
        if (accept && !drain) state_nxt = ST_TWO;
        else if (!accept && drain) state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (drain) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  // in_ready and out_valid are registered copies of the next-state decode.
  // A new beat goes straight to the head when the head is empty or leaving;
  // otherwise it parks in the skid entry, which moves up on the next drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_EMPTY;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_fmt      <= FMT_NONE;
      out_pc       <= '0;
      out_target   <= '0;
      out_illegal  <= 1'b0;
      skid_imm     <= '0;
      skid_fmt     <= FMT_NONE;
      skid_pc      <= '0;
      skid_target  <= '0;
      skid_illegal <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != ST_TWO);
      out_valid <= (state_nxt != ST_EMPTY);
      if (!flush) begin
        if (accept && (state == ST_EMPTY || (state == ST_ONE && drain))) begin
          out_imm     <= dec_imm;
          out_fmt     <= dec_fmt;
          out_pc      <= in_pc;
          out_target  <= dec_target;
          out_illegal <= dec_illegal;
        end else if (accept && state == ST_ONE) begin
          skid_imm     <= dec_imm;
          skid_fmt     <= dec_fmt;
          skid_pc      <= in_pc;
          skid_target  <= dec_target;
          skid_illegal <= dec_illegal;
        end else if (drain && state == ST_TWO) begin
          out_imm     <= skid_imm;
          out_fmt     <= skid_fmt;
          out_pc      <= skid_pc;
          out_target  <= skid_target;
          out_illegal <= skid_illegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage
// Drives an RV32 and an RV64 instance of imm_decode_stage from the same
// stimulus and checks both against a queue-based model of the stage plus
// hand-computed expected values.
module tb_imm_decode_stage;

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] pc;
    logic [63:0] tgt;
  } exp_t;

  typedef struct packed {
    exp_t e32;
    exp_t e64;
  } beat_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] pc;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill32;
    logic        ill64;
    logic [63:0] tgt32;
    logic [63:0] tgt64;
  } vec_t;

  localparam int NV = 14;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [31:0] pc32;
  logic        flush;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_pc32, out_target32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64, out_pc64, out_target64;
  logic [2:0]  out_fmt64;

  int tests_run;
  int tests_failed;

  beat_t exp_q[$];
  bit    m_acc;
  bit    m_drn;
  vec_t  vecs [NV];

  assign pc32 = in_pc[31:0];

  imm_decode_stage #(.XLEN(32), .ZIMM_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(pc32), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_pc(out_pc32), .out_target(out_target32),
    .out_illegal(out_illegal32)
  );

  imm_decode_stage #(.XLEN(64), .ZIMM_EN(1'b1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_pc(out_pc64), .out_target(out_target64),
    .out_illegal(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                               input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Two's-complement reinterpretation of a bits-wide field value.
  function automatic longint wrapSigned(input longint raw, input int bits);
    if (raw >= (longint'(1) << (bits - 1))) return raw - (longint'(1) << bits);
    return raw;
  endfunction

  function automatic exp_t decodeModel(input logic [31:0] ins, input logic [63:0] pc, input bit is64);
    exp_t        e;
    longint      v;
    logic [63:0] mask;
    mask  = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    v     = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    if (ins[1:0] != 2'b11) begin
      e.ill = 1'b1;
    end else begin
      case (ins[6:0])
        7'h13, 7'h03, 7'h67: begin
          e.fmt = 3'd1;
          v = wrapSigned(longint'(ins[31:20]), 12);
        end
        7'h23: begin
          e.fmt = 3'd2;
          v = wrapSigned(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
        end
        7'h63: begin
          e.fmt = 3'd3;
          v = wrapSigned(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                         longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
        end
        7'h37, 7'h17: begin
          e.fmt = 3'd4;
          v = wrapSigned(longint'(ins[31:12]) * 4096, 32);
        end
        7'h6F: begin
          e.fmt = 3'd5;
          v = wrapSigned(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                         longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
        end
        7'h73: begin
          if (ins[14]) begin
            e.fmt = 3'd6;
            v = longint'(ins[19:15]);
          end
        end
        7'h33, 7'h0F: e.ill = 1'b0;
        7'h3B:        e.ill = !is64;
        default:      e.ill = 1'b1;
      endcase
    end
    e.imm = 64'(v) & mask;
    e.pc  = pc & mask;
    e.tgt = (pc + 64'(v)) & mask;
    return e;
  endfunction

  // Reference stage: an ordered queue of at most two decoded beats.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      m_drn = (exp_q.size() > 0) && out_ready;
      m_acc = in_valid && (exp_q.size() < 2);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_drn) exp_q.delete(0);
        if (m_acc) exp_q.push_back('{decodeModel(in_instr, in_pc, 1'b0),
                                     decodeModel(in_instr, in_pc, 1'b1)});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("in_ready32",  in_ready32,  exp_q.size() < 2);
      checkOutput("in_ready64",  in_ready64,  exp_q.size() < 2);
      checkOutput("out_valid32", out_valid32, exp_q.size() > 0);
      checkOutput("out_valid64", out_valid64, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        checkOutput("model_imm32", out_imm32,     exp_q[0].e32.imm);
        checkOutput("model_fmt32", out_fmt32,     exp_q[0].e32.fmt);
        checkOutput("model_ill32", out_illegal32, exp_q[0].e32.ill);
        checkOutput("model_pc32",  out_pc32,      exp_q[0].e32.pc);
        checkOutput("model_tgt32", out_target32,  exp_q[0].e32.tgt);
        checkOutput("model_imm64", out_imm64,     exp_q[0].e64.imm);
        checkOutput("model_fmt64", out_fmt64,     exp_q[0].e64.fmt);
        checkOutput("model_ill64", out_illegal64, exp_q[0].e64.ill);
        checkOutput("model_pc64",  out_pc64,      exp_q[0].e64.pc);
        checkOutput("model_tgt64", out_target64,  exp_q[0].e64.tgt);
      end
    end
  end

  initial begin
    int  tries;
    bit  took;
    int  cyc;

    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;

    //           ins           pc                     imm32         imm64                  fmt  i32   i64   tgt32         tgt64
    vecs[0]  = '{32'hFFF00093, 64'h0,                64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    vecs[1]  = '{32'hFE000EE3, 64'h100,              64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0, 1'b0, 64'hFC,       64'hFC};
    vecs[2]  = '{32'h0010006F, 64'h100,              64'h800,      64'h800,              3'd5, 1'b0, 1'b0, 64'h900,      64'h900};
    vecs[3]  = '{32'h800000B7, 64'h0,                64'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0, 1'b0, 64'h80000000, 64'hFFFFFFFF80000000};
    vecs[4]  = '{32'h0052D073, 64'h0,                64'h5,        64'h5,                3'd6, 1'b0, 1'b0, 64'h5,        64'h5};
    vecs[5]  = '{32'h00000000, 64'h0,                64'h0,        64'h0,                3'd0, 1'b1, 1'b1, 64'h0,        64'h0};
    vecs[6]  = '{32'h00B5053B, 64'h40,               64'h0,        64'h0,                3'd0, 1'b1, 1'b0, 64'h40,       64'h40};
    vecs[7]  = '{32'h00000073, 64'h40,               64'h0,        64'h0,                3'd0, 1'b0, 1'b0, 64'h40,       64'h40};
    vecs[8]  = '{32'h02000093, 64'hFFFFFFFFFFFFFFF0, 64'h20,       64'h20,               3'd1, 1'b0, 1'b0, 64'h10,       64'h10};
    vecs[9]  = '{32'hFE512C23, 64'h200,              64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd2, 1'b0, 1'b0, 64'h1F8,      64'h1F8};
    vecs[10] = '{32'h00000001, 64'h0,                64'h0,        64'h0,                3'd0, 1'b1, 1'b1, 64'h0,        64'h0};
    vecs[11] = '{32'h30529073, 64'h0,                64'h0,        64'h0,                3'd0, 1'b0, 1'b0, 64'h0,        64'h0};
    vecs[12] = '{32'h00001037, 64'h10,               64'h1000,     64'h1000,             3'd4, 1'b0, 1'b0, 64'h1010,     64'h1010};
    vecs[13] = '{32'h000080E7, 64'h80,               64'h0,        64'h0,                3'd1, 1'b0, 1'b0, 64'h80,       64'h80};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_pc     = 64'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_out_valid32", out_valid32,   1'b0);
    checkOutput("rst_in_ready32",  in_ready32,    1'b1);
    checkOutput("rst_out_imm32",   out_imm32,     32'h0);
    checkOutput("rst_out_fmt32",   out_fmt32,     3'd0);
    checkOutput("rst_out_pc32",    out_pc32,      32'h0);
    checkOutput("rst_out_tgt32",   out_target32,  32'h0);
    checkOutput("rst_out_ill32",   out_illegal32, 1'b0);
    checkOutput("rst_out_valid64", out_valid64,   1'b0);
    checkOutput("rst_in_ready64",  in_ready64,    1'b1);
    checkOutput("rst_out_imm64",   out_imm64,     64'h0);
    rst = 1'b0;
    @(negedge clk);

    // One beat per cycle with downstream always ready: each result appears one edge after its accept.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(1'b1, vecs[i].ins, vecs[i].pc, 1'b1, 1'b0);
      checkOutput($sformatf("vec%0d_valid32", i), out_valid32,   1'b1);
      checkOutput($sformatf("vec%0d_imm32", i),   out_imm32,     vecs[i].imm32);
      checkOutput($sformatf("vec%0d_fmt32", i),   out_fmt32,     vecs[i].fmt);
      checkOutput($sformatf("vec%0d_ill32", i),   out_illegal32, vecs[i].ill32);
      checkOutput($sformatf("vec%0d_tgt32", i),   out_target32,  vecs[i].tgt32);
      checkOutput($sformatf("vec%0d_imm64", i),   out_imm64,     vecs[i].imm64);
      checkOutput($sformatf("vec%0d_fmt64", i),   out_fmt64,     vecs[i].fmt);
      checkOutput($sformatf("vec%0d_ill64", i),   out_illegal64, vecs[i].ill64);
      checkOutput($sformatf("vec%0d_tgt64", i),   out_target64,  vecs[i].tgt64);
    end
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("drain_idle_valid", out_valid32, 1'b0);

    // Back-pressure: A and B fill the buffer, C waits, then all three leave in order.
    applyStimulus(1'b1, 32'h00100093, 64'hA00, 1'b0, 1'b0);
    checkOutput("bp_a_ready", in_ready32, 1'b1);
    applyStimulus(1'b1, 32'h00200093, 64'hB00, 1'b0, 1'b0);
    checkOutput("bp_b_ready", in_ready32, 1'b0);
    applyStimulus(1'b1, 32'h00300093, 64'hC00, 1'b0, 1'b0);
    checkOutput("bp_hold_pc", out_pc32, 32'hA00);
    checkOutput("bp_hold_imm", out_imm32, 32'h1);
    applyStimulus(1'b1, 32'h00300093, 64'hC00, 1'b1, 1'b0);
    checkOutput("bp_second_pc", out_pc32, 32'hB00);
    applyStimulus(1'b1, 32'h00300093, 64'hC00, 1'b1, 1'b0);
    checkOutput("bp_third_pc", out_pc32, 32'hC00);
    checkOutput("bp_third_imm", out_imm32, 32'h3);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("bp_empty_valid", out_valid32, 1'b0);

    // Flush while full with a new beat offered: everything is dropped.
    applyStimulus(1'b1, 32'h00400093, 64'hD00, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00500093, 64'hE00, 1'b0, 1'b0);
    checkOutput("fl_full_ready", in_ready32, 1'b0);
    applyStimulus(1'b1, 32'h00600093, 64'hF00, 1'b0, 1'b1);
    checkOutput("fl_valid", out_valid32, 1'b0);
    checkOutput("fl_ready", in_ready32, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      checkOutput("fl_after_valid", out_valid64, 1'b0);
    end

    // Flush in a cycle that also drains.
    applyStimulus(1'b1, 32'h00700093, 64'h700, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00800093, 64'h800, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b1);
    checkOutput("fl_drain_valid", out_valid32, 1'b0);
    applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("fl_drain_after", out_valid32, 1'b0);

    // Asynchronous reset between edges while one beat is held.
    applyStimulus(1'b1, 32'h00900093, 64'h900, 1'b0, 1'b0);
    checkOutput("ar_before_valid", out_valid32, 1'b1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_valid32", out_valid32, 1'b0);
    checkOutput("ar_valid64", out_valid64, 1'b0);
    checkOutput("ar_ready32", in_ready32,  1'b1);
    checkOutput("ar_imm32",   out_imm32,   32'h0);
    checkOutput("ar_pc64",    out_pc64,    64'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      checkOutput("ar_after_valid", out_valid32, 1'b0);
    end

    // Whole table again with downstream stalling every third cycle.
    for (int i = 0; i < NV; i++) begin
      took  = 1'b0;
      tries = 0;
      while (!took && tries < 10) begin
        took = (exp_q.size() < 2);
        applyStimulus(1'b1, vecs[i].ins, vecs[i].pc, (cyc % 3) != 0, 1'b0);
        cyc++;
        tries++;
      end
      checkOutput("mix_accept", took, 1'b1);
    end
    repeat (4) applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("mix_end_valid", out_valid32, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
